// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/capture stage around an external WIDTH-bit ripple ALU built
// from 1-bit slices. Accepts one request, drives the ALU for one cycle from registered
// operands, then holds the captured result until the consumer takes it.
// Optional macro ALU_FLAGS_EN compiles the zero/carry/overflow flag logic; without it
// out_z, out_c and out_v are tied to 0.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic             out_err
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpPass = 3'b100;
  localparam logic [2:0] OpInc  = 3'b101;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [1:0]       alu_s_q, alu_s_d;
  logic             arith_q, arith_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_z_q, out_z_d;
  logic             out_c_q, out_c_d;
  logic             out_v_q, out_v_d;
  logic             out_err_q, out_err_d;

  logic [WIDTH-1:0] dec_b;
  logic             dec_cin;
  logic [1:0]       dec_s;
  logic             dec_arith;
  logic             dec_err;

  // Decode the incoming opcode into slice select, B operand, carry-in and op class
  always_comb begin
    dec_b     = in_b;
    dec_cin   = 1'b0;
    dec_s     = 2'b00;
    dec_arith = 1'b0;
    dec_err   = 1'b0;
    case (in_op)
      OpAdd:  dec_arith = 1'b1;
      OpSub: begin
        dec_b     = ~in_b;
        dec_cin   = 1'b1;
        dec_arith = 1'b1;
      end
      OpAnd:  dec_s = 2'b01;
      OpOr:   dec_s = 2'b10;
      OpPass: dec_s = 2'b11;
      OpInc: begin
        dec_b     = '0;
        dec_cin   = 1'b1;
        dec_arith = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  logic flag_z, flag_c, flag_v;

`ifdef ALU_FLAGS_EN
  // Status flags from the settled ALU; overflow uses the post-inversion B operand
  always_comb begin
    flag_z = (alu_y == '0);
    flag_c = arith_q & alu_cout;
    flag_v = arith_q & (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) &
             (alu_y[WIDTH-1] != alu_a_q[WIDTH-1]);
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = alu_cout ^ arith_q;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

  // Next-state: accept in IDLE, capture at the end of EXEC, hold in DONE until taken
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_s_d     = alu_s_q;
    arith_d     = arith_q;
    err_d       = err_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    out_c_d     = out_c_q;
    out_v_d     = out_v_q;
    out_err_d   = out_err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StExec;
          in_ready_d = 1'b0;
          alu_a_d    = in_a;
          alu_b_d    = dec_b;
          alu_cin_d  = dec_cin;
          alu_s_d    = dec_s;
          arith_d    = dec_arith;
          err_d      = dec_err;
        end
      end
      StExec: begin
        state_d     = StDone;
        out_valid_d = 1'b1;
        out_y_d     = err_q ? '0 : alu_y;
        out_z_d     = ~err_q & flag_z;
        out_c_d     = ~err_q & flag_c;
        out_v_d     = ~err_q & flag_v;
        out_err_d   = err_q;
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_s_q     <= 2'b00;
      arith_q     <= 1'b0;
      err_q       <= 1'b0;
      out_y_q     <= '0;
      out_z_q     <= 1'b0;
      out_c_q     <= 1'b0;
      out_v_q     <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_s_q     <= alu_s_d;
      arith_q     <= arith_d;
      err_q       <= err_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      out_c_q     <= out_c_d;
      out_v_q     <= out_v_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_s     = alu_s_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign out_c     = out_c_q;
  assign out_v     = out_v_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU model on the slice port, a vector
// table of operations, a scoreboard queue checked on each output handshake, and
// hand-written reset-in-EXEC / reset-in-DONE sequences.
module tb_alu_op_sequencer;

  localparam int W = 32;

`ifdef ALU_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_cin, alu_cout;
  logic [1:0]   alu_s;
  logic         out_valid, out_ready;
  logic [W-1:0] out_y;
  logic         out_z, out_c, out_v, out_err;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_s    (alu_s),
    .alu_y    (alu_y),
    .alu_cout (alu_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_z    (out_z),
    .out_c    (out_c),
    .out_v    (out_v),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  // Behavioural model of the chained 1-bit slices
  always_comb begin
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_s)
      2'b00:   {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
      2'b01:   alu_y = alu_a & alu_b;
      2'b10:   alu_y = alu_a | alu_b;
      default: alu_y = alu_a;
    endcase
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ab;    // expected alu_b during EXEC
    logic         cin;
    logic [1:0]   s;
    logic         chk_alu;
    logic [W-1:0] y;
    logic         z, c, v, err;
    int           hold;  // extra DONE cycles with out_ready low
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic         z, c, v, err;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each accepted result against the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got y=%h with no pending request", out_y);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_y", out_y, e.y);
        check1("out_z", out_z, e.z);
        check1("out_c", out_c, e.c);
        check1("out_v", out_v, e.v);
        check1("out_err", out_err, e.err);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1 within 20 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_op    = v.op;
    @(posedge clk);
    #1;
    e.y   = v.y;
    e.z   = FlagsEn ? v.z : 1'b0;
    e.c   = FlagsEn ? v.c : 1'b0;
    e.v   = FlagsEn ? v.v : 1'b0;
    e.err = v.err;
    sbq.push_back(e);
    // Scramble inputs: ALU operands must come from registers only
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_op    = 3'($urandom);
    @(negedge clk);
    check1("exec_in_ready", in_ready, 1'b0);
    check1("exec_out_valid", out_valid, 1'b0);
    if (v.chk_alu) begin
      check("exec_alu_a", alu_a, v.a);
      check("exec_alu_b", alu_b, v.ab);
      check1("exec_alu_cin", alu_cin, v.cin);
      check("exec_alu_s", {30'b0, alu_s}, {30'b0, v.s});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;  // must be ignored while busy
    in_op    = 3'b000;
    @(negedge clk);
    check1("done_out_valid", out_valid, 1'b1);
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check1("hold_out_valid", out_valid, 1'b1);
      check1("hold_in_ready", in_ready, 1'b0);
      check("hold_out_y", out_y, v.y);
      check1("hold_out_err", out_err, v.err);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check1("idle_out_valid", out_valid, 1'b0);
    check1("idle_in_ready", in_ready, 1'b1);
  endtask

  // Accept a PASS, then reset during EXEC (in_done=0) or DONE (in_done=1)
  task automatic rst_seq(input bit in_done, input string tag);
    wait_ready();
    in_valid = 1'b1;
    in_a     = 32'h12345678;
    in_b     = 32'h9ABCDEF0;
    in_op    = 3'b100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (in_done) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check1({tag, "_pre_valid"}, out_valid, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_y"}, out_y, '0);
    check({tag, "_alu_a"}, alu_a, '0);
    check({tag, "_alu_b"}, alu_b, '0);
    check1({tag, "_alu_cin"}, alu_cin, 1'b0);
    check({tag, "_alu_s"}, {30'b0, alu_s}, '0);
    check1({tag, "_flags"}, out_z | out_c | out_v | out_err, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check1({tag, "_no_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op      a             b             alu_b         cin   s      chk   y             z     c     v     err   hold
    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 2'b00, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h00000001, 32'hFFFFFFFE, 1'b1, 2'b00, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFF00FF00, 1'b0, 2'b01, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    vecs[3]  = '{3'b011, 32'h0F0F0000, 32'h00F0000F, 32'h00F0000F, 1'b0, 2'b10, 1'b1, 32'h0FFF000F, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{3'b100, 32'h12345678, 32'hABCDEF01, 32'hABCDEF01, 1'b0, 2'b11, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[5]  = '{3'b111, 32'h12345678, 32'h12345678, 32'h0,        1'b0, 2'b00, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'b101, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h00000000, 1'b1, 2'b00, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[7]  = '{3'b001, 32'h00000005, 32'h00000005, 32'hFFFFFFFA, 1'b1, 2'b00, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFA, 1'b1, 2'b00, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 2'b00, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[10] = '{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 2'b00, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 3'b000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_alu_a", alu_a, '0);
    check("rst_alu_b", alu_b, '0);
    check1("rst_alu_cin", alu_cin, 1'b0);
    check("rst_alu_s", {30'b0, alu_s}, '0);
    for (int k = 0; k < 10; k++) begin
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check("rst_out_y", out_y, '0);
      check1("rst_flags", out_z | out_c | out_v | out_err, 1'b0);
      @(negedge clk);
    end
    #1;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      @(posedge clk);
      #1;
    end

    rst_seq(1'b0, "rst_exec");
    rst_seq(1'b1, "rst_done");
    @(posedge clk);
    #1;
    run_vec(vecs[0]);

    @(negedge clk);
    check("sb_empty", 32'(sbq.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
